// File: rtl/segment_scan_decoder.sv
// Rebuilds a packed BCD value from a multiplexed seven-segment bus.
// A value is published once STABLE_SCANS identical, fully decodable frames have been seen.
module segment_scan_decoder #(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned STABLE_SCANS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic                  seg_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  seg_err,
  output logic                  frame_bad
);

  localparam int unsigned CW = $clog2(STABLE_SCANS + 1);

  typedef enum logic {S_COLLECT, S_EVAL} state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_cap;
  logic [DIGITS-1:0]   r_cap_inv;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_frame;
  logic [DIGITS-1:0]   r_frame_inv;
  logic [4*DIGITS-1:0] r_prev;
  logic                r_prev_ok;
  logic [CW-1:0]       r_cnt;
  logic                r_pub;

  logic [4:0]          w_dec;
  logic                w_onehot;
  logic                w_accept;
  logic [4*DIGITS-1:0] w_cap_nxt;
  logic [DIGITS-1:0]   w_inv_nxt;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic                w_frame_done;
  logic                w_frame_ok;
  logic [CW-1:0]       w_cnt_nxt;

  // {valid, nibble}; only exact patterns decode
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'b0111111: f_decode = {1'b1, 4'd0};
      7'b0000110: f_decode = {1'b1, 4'd1};
      7'b1011011: f_decode = {1'b1, 4'd2};
      7'b1001111: f_decode = {1'b1, 4'd3};
      7'b1100110: f_decode = {1'b1, 4'd4};
      7'b1101101: f_decode = {1'b1, 4'd5};
      7'b1111101: f_decode = {1'b1, 4'd6};
      7'b0000111: f_decode = {1'b1, 4'd7};
      7'b1111111: f_decode = {1'b1, 4'd8};
      7'b1100111: f_decode = {1'b1, 4'd9};
      default:    f_decode = {1'b0, 4'd0};
    endcase
  endfunction

  always_comb begin
    w_dec      = f_decode(seg_in);
    w_onehot   = $onehot(digit_sel);
    w_accept   = seg_valid && w_onehot;
    w_cap_nxt  = r_cap;
    w_inv_nxt  = r_cap_inv;
    w_seen_nxt = r_seen;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_accept && digit_sel[i]) begin
        w_cap_nxt[4*i +: 4] = w_dec[3:0];
        w_inv_nxt[i]        = ~w_dec[4];
        w_seen_nxt[i]       = 1'b1;
      end
    end
    w_frame_done = (r_state == S_COLLECT) && w_accept && (&w_seen_nxt);
    w_frame_ok   = ~|r_frame_inv;
    if (r_prev_ok && (r_frame == r_prev))
      w_cnt_nxt = (r_cnt == CW'(STABLE_SCANS)) ? r_cnt : r_cnt + CW'(1);
    else
      w_cnt_nxt = CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_COLLECT;
      r_cap       <= '0;
      r_cap_inv   <= '0;
      r_seen      <= '0;
      r_frame     <= '0;
      r_frame_inv <= '0;
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_cnt       <= '0;
      r_pub       <= 1'b0;
      bcd_out     <= '0;
      bcd_valid   <= 1'b0;
      seg_err     <= 1'b0;
      frame_bad   <= 1'b0;
    end else begin
      seg_err   <= seg_valid && (!w_onehot || !w_dec[4]);
      bcd_valid <= 1'b0;
      frame_bad <= 1'b0;
      r_cap     <= w_cap_nxt;
      r_cap_inv <= w_inv_nxt;
      case (r_state)
        S_COLLECT: begin
          if (w_frame_done) begin
            r_frame     <= w_cap_nxt;
            r_frame_inv <= w_inv_nxt;
            r_seen      <= '0;
            r_state     <= S_EVAL;
          end else begin
            r_seen <= w_seen_nxt;
          end
        end
        S_EVAL: begin
          // capture keeps running into the next frame while the last one is judged
          r_seen  <= w_seen_nxt;
          r_state <= S_COLLECT;
          if (!w_frame_ok) begin
            frame_bad <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt     <= w_cnt_nxt;
            r_prev    <= r_frame;
            r_prev_ok <= 1'b1;
            if ((w_cnt_nxt == CW'(STABLE_SCANS)) && (!r_pub || (r_frame != bcd_out))) begin
              bcd_out   <= r_frame;
              bcd_valid <= 1'b1;
              r_pub     <= 1'b1;
            end
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder (DIGITS=2, STABLE_SCANS=2).
module tb_segment_scan_decoder;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1100111;
  localparam logic [6:0] PX = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = '0;
  logic [1:0] digit_sel = '0;
  logic       seg_valid = 1'b0;
  logic [7:0] bcd_out;
  logic       bcd_valid, seg_err, frame_bad;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0, n_err = 0, n_bad = 0;
  int last_valid_cyc = -1, last_err_cyc = -1, last_bad_cyc = -1;
  int last_sample_cyc = 0;
  int base_valid, base_err, base_bad, mark;

  segment_scan_decoder #(.DIGITS(2), .STABLE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel),
    .seg_valid(seg_valid), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .seg_err(seg_err), .frame_bad(frame_bad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bcd_valid) begin n_valid++; last_valid_cyc = cyc; end
    if (seg_err)   begin n_err++;   last_err_cyc   = cyc; end
    if (frame_bad) begin n_bad++;   last_bad_cyc   = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] sel, input logic [6:0] seg, input logic vld);
    @(negedge clk);
    digit_sel = sel;
    seg_in    = seg;
    seg_valid = vld;
    if (vld) last_sample_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 7'b0, 1'b0);
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1);
    step(2'b01, d0, 1'b1);
    step(2'b10, d1, 1'b1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    seg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mark_counts;
    base_valid = n_valid;
    base_err   = n_err;
    base_bad   = n_bad;
  endtask

  initial begin
    do_reset();
    #1;
    chk("reset_bcd_out", 32'(bcd_out), 32'h0);
    chk("reset_flags", {29'd0, bcd_valid, seg_err, frame_bad}, 32'h0);

    // Two identical 42 scans publish once, exactly two cycles after the last sample
    mark_counts();
    scan(P2, P4);
    scan(P2, P4);
    mark = last_sample_cyc;
    idle(3);
    chk("t1_pulses", 32'(n_valid - base_valid), 32'd1);
    chk("t1_latency", 32'(last_valid_cyc), 32'(mark + 2));
    chk("t1_value", 32'(bcd_out), 32'h42);
    mark_counts();
    scan(P2, P4);
    idle(3);
    chk("t1_hold_nopulse", 32'(n_valid - base_valid), 32'd0);
    chk("t1_hold_value", 32'(bcd_out), 32'h42);

    // 42, 43, 43
    do_reset();
    mark_counts();
    scan(P2, P4);
    scan(P3, P4);
    idle(3);
    chk("t2_no_pub", 32'(n_valid - base_valid), 32'd0);
    chk("t2_value0", 32'(bcd_out), 32'h0);
    scan(P3, P4);
    mark = last_sample_cyc;
    idle(3);
    chk("t2_pulses", 32'(n_valid - base_valid), 32'd1);
    chk("t2_latency", 32'(last_valid_cyc), 32'(mark + 2));
    chk("t2_value", 32'(bcd_out), 32'h43);

    // Undecodable digit breaks the run; two more good scans needed
    do_reset();
    mark_counts();
    scan(P2, P4);
    scan(P2, PX);
    mark = last_sample_cyc;
    scan(P2, P4);
    idle(3);
    chk("t3_seg_err", 32'(n_err - base_err), 32'd1);
    chk("t3_err_time", 32'(last_err_cyc), 32'(mark + 1));
    chk("t3_frame_bad", 32'(n_bad - base_bad), 32'd1);
    chk("t3_bad_time", 32'(last_bad_cyc), 32'(mark + 2));
    chk("t3_no_pub", 32'(n_valid - base_valid), 32'd0);
    scan(P2, P4);
    mark = last_sample_cyc;
    idle(3);
    chk("t3_pulses", 32'(n_valid - base_valid), 32'd1);
    chk("t3_latency", 32'(last_valid_cyc), 32'(mark + 2));
    chk("t3_value", 32'(bcd_out), 32'h42);

    // Non-one-hot selects are dropped without marking digits seen
    do_reset();
    mark_counts();
    step(2'b01, P2, 1'b1);
    step(2'b11, P4, 1'b1);
    step(2'b00, P4, 1'b1);
    step(2'b10, P4, 1'b1);
    idle(3);
    chk("t4_seg_err", 32'(n_err - base_err), 32'd2);
    chk("t4_no_pub", 32'(n_valid - base_valid), 32'd0);
    chk("t4_no_bad", 32'(n_bad - base_bad), 32'd0);
    scan(P2, P4);
    mark = last_sample_cyc;
    idle(3);
    chk("t4_pulses", 32'(n_valid - base_valid), 32'd1);
    chk("t4_latency", 32'(last_valid_cyc), 32'(mark + 2));
    chk("t4_value", 32'(bcd_out), 32'h42);

    // 98 then 00
    do_reset();
    mark_counts();
    scan(P8, P9);
    scan(P8, P9);
    idle(3);
    chk("t5_value98", 32'(bcd_out), 32'h98);
    scan(P0, P0);
    scan(P0, P0);
    mark = last_sample_cyc;
    idle(3);
    chk("t5_pulses", 32'(n_valid - base_valid), 32'd2);
    chk("t5_latency00", 32'(last_valid_cyc), 32'(mark + 2));
    chk("t5_value00", 32'(bcd_out), 32'h00);

    // Reset mid-frame clears outputs and match history
    do_reset();
    scan(P2, P4);
    scan(P2, P4);
    idle(3);
    chk("t6_pre_value", 32'(bcd_out), 32'h42);
    step(2'b01, P2, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    seg_valid = 1'b0;
    #1;
    chk("t6_async_bcd", 32'(bcd_out), 32'h0);
    chk("t6_async_flags", {29'd0, bcd_valid, seg_err, frame_bad}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mark_counts();
    step(2'b10, P4, 1'b1);
    scan(P2, P4);
    idle(3);
    chk("t6_no_pub", 32'(n_valid - base_valid), 32'd0);
    chk("t6_value0", 32'(bcd_out), 32'h0);
    scan(P2, P4);
    idle(3);
    chk("t6_pulses", 32'(n_valid - base_valid), 32'd1);
    chk("t6_value", 32'(bcd_out), 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_scan_decoder.md
# segment_scan_decoder

Receive-side counterpart of the team's BCD-to-seven-segment display driver: samples a multiplexed seven-segment bus (one digit pattern plus a one-hot digit select per sample) and rebuilds the packed BCD value. It assembles a full scan frame across all digits and decodes each pattern back to a nibble. A value is published only after `STABLE_SCANS` consecutive identical, fully valid frames. Used by test fixtures and front-panel readback to check what the display path is actually showing.

## Interface
- `DIGITS`, default 2: number of display digits (≥1); digit 0 is least significant.
- `STABLE_SCANS`, default 2: consecutive identical valid frames required before publishing (≥1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `seg_in`  in  7  segment pattern, active-high, bit 0 = a … bit 6 = g.
- `digit_sel`  in  DIGITS  one-hot digit index for `seg_in`.
- `seg_valid`  in  1  `seg_in`/`digit_sel` valid this cycle.
- `bcd_out`  out  4*DIGITS  last published value; digit i at bits [4i+3:4i].
- `bcd_valid`  out  1  one-cycle pulse when `bcd_out` changes.
- `seg_err`  out  1  one-cycle pulse: rejected sample.
- `frame_bad`  out  1  one-cycle pulse: completed frame contained an undecodable digit.

## Operation
- Decode table (exact match only): 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1100111→9. Any other pattern is undecodable.
- Accepted sample: `seg_valid`=1 and `digit_sel` exactly one-hot. Nibble and a per-digit invalid flag are written to capture slot i; `seen[i]` set. Repeat of a digit within a frame overwrites (latest wins).
- Non-one-hot `digit_sel` with `seg_valid`=1: sample dropped, `seen` unchanged, `seg_err` pulses. Undecodable pattern: stored with invalid flag, `seg_err` pulses.
- States: COLLECT, EVAL.
- COLLECT: when an accepted sample makes `seen` all-ones, the complete frame (including that sample) is copied to the frame register, `seen` cleared, go to EVAL.
- EVAL (one cycle, always returns to COLLECT): samples accepted normally into the new frame.
  - Any invalid digit: `frame_bad` pulses, match count ← 0.
  - All valid and equal to previous valid frame: match count ← min(count+1, STABLE_SCANS).
  - All valid, different or no previous: match count ← 1.
  - Previous-frame register updated with every valid frame.
- Publish: when the new match count equals `STABLE_SCANS` and (nothing published yet, or frame ≠ `bcd_out`), load `bcd_out`, pulse `bcd_valid`. Holding a stable value produces no further pulses.
- Match counter width: $clog2(STABLE_SCANS+1); saturates, never wraps.

## Timing
- Reset (async assert, sync release): `bcd_out`=0, `bcd_valid`=0, `seg_err`=0, `frame_bad`=0, `seen`=0, match count 0, published flag clear, state COLLECT.
- `seg_err` is high the cycle after the offending sample.
- Frame-completing sample in cycle k: EVAL in k+1. `frame_bad` and `bcd_valid` are high in cycle k+2, and `bcd_out` holds the new value from k+2.
- Back-to-back frames at one sample per cycle are supported with no dropped samples.
- Reset mid-frame discards partial capture and match history; `bcd_out` returns to 0.

## Test plan
- DIGITS=2, STABLE_SCANS=2. Scan digit0=1011011, digit1=1100110 twice at one sample per cycle -> `bcd_out`=8'h42, single `bcd_valid` pulse 2 cycles after the last sample of the second scan. A third identical scan produces no pulse.
- Scans 42, 43, 43 -> no publish after scan 2; `bcd_out`=8'h43 with pulse after scan 3 only.
- Scan with digit1=0000000 between two good 42 scans -> `seg_err` pulse, `frame_bad` pulse, no publish. Two further 42 scans are required before the pulse.
- `digit_sel`=2'b11 or 2'b00 with `seg_valid`=1 -> `seg_err` pulse, `seen` unchanged, frame completes only after a proper sample for each digit.
- Patterns 1111111/1100111 on digit0/digit1, two scans -> `bcd_out`=8'h98. Then 0111111/0111111 twice -> `bcd_out`=8'h00 with pulse.
- Assert `reset` after one digit of a second identical scan -> all outputs 0 immediately. After release, two full scans are needed to publish.
